// File: rtl/fetch_inst_queue.sv
// ============================================================================
// fetch_inst_queue
// ----------------------------------------------------------------------------
// Instruction queue between the fetch pre-decode/branch-check stage and
// decode. Each cycle it takes up to FETCH_WIDTH instructions with a per-lane
// valid mask that may contain holes. It compacts the valid lanes in program
// order into a circular buffer and issues up to DECODE_WIDTH instructions per
// cycle, oldest first. Any front-end redirect flushes the whole queue.
//
// Parameters
//   FETCH_WIDTH   enqueue lanes per cycle
//   DECODE_WIDTH  dequeue lanes per cycle
//   DEPTH         number of entries; power of two, >= 2*FETCH_WIDTH
//
// Ports
//   clk            clock
//   rst_n          asynchronous reset, active low
//   flush_i        discard all contents (redirect), takes effect next cycle
//   in_valid_i     per-lane enqueue valid mask (holes allowed)
//   in_pc_i        enqueue lane PCs, lane i at [i*32 +: 32]
//   in_inst_i      enqueue lane instruction words
//   in_taken_i     enqueue lane predicted-taken flags
//   in_ready_o     queue has room for a full fetch group
//   out_valid_o    issue-lane valids, always a contiguous low-order run
//   out_pc_o       issue-lane PCs (zero on lanes that are not valid)
//   out_inst_o     issue-lane instruction words (zero on invalid lanes)
//   out_taken_o    issue-lane predicted-taken flags (zero on invalid lanes)
//   out_ready_i    decode accepts every asserted out_valid_o lane
//
// Handshake
//   Enqueue fires when |in_valid_i && in_ready_o && !flush_i. in_ready_o is
//   derived from the registered occupancy only, so a dequeue in the same
//   cycle never raises it. A group offered while in_ready_o is low is dropped;
//   upstream must hold it and offer it again.
//   Dequeue fires when out_ready_i && !flush_i and then retires every lane
//   that out_valid_o currently shows; decode may not take a partial run.
//
// Optional build macro
//   FETCH_QUEUE_PERF_EN  adds perf_full_cycles_o[31:0] (cycles with a valid
//                        fetch group but no room) and perf_flush_cnt_o[31:0]
//                        (cycles with flush_i high). Both saturate at all
//                        ones, reset to 0 and ignore flush.
// ============================================================================
module fetch_inst_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic [FETCH_WIDTH-1:0]    in_valid_i,
    input  logic [FETCH_WIDTH*32-1:0] in_pc_i,
    input  logic [FETCH_WIDTH*32-1:0] in_inst_i,
    input  logic [FETCH_WIDTH-1:0]    in_taken_i,
    output logic                      in_ready_o,
    output logic [DECODE_WIDTH-1:0]   out_valid_o,
    output logic [DECODE_WIDTH*32-1:0] out_pc_o,
    output logic [DECODE_WIDTH*32-1:0] out_inst_o,
    output logic [DECODE_WIDTH-1:0]   out_taken_o,
    input  logic                      out_ready_i
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]               perf_full_cycles_o,
    output logic [31:0]               perf_flush_cnt_o
`endif
);

    // AW index bits; the extra MSB of head/tail is the wrap bit, which lets
    // tail - head express the full range 0..DEPTH without ambiguity.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0] r_head;
    logic [CW-1:0] r_tail;

    // Entry storage. Not reset and not cleared on flush: the pointers alone
    // decide what is live, and invalid output lanes are forced to zero.
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_inst  [DEPTH];
    logic          r_taken [DEPTH];

    // ------------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------------
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;

    assign w_count    = r_tail - r_head;
    assign w_free     = DEPTH_C - w_count;
    assign in_ready_o = (w_free >= FW_C);

    // ------------------------------------------------------------------------
    // Enqueue compaction
    // Lane i lands at tail + (number of valid lanes below i), so holes in the
    // mask are squeezed out and program order is preserved.
    // ------------------------------------------------------------------------
    logic [CW-1:0] w_enq_n;
    logic [AW-1:0] w_wr_idx [FETCH_WIDTH];
    logic          w_enq_fire;

    always_comb begin
        w_enq_n = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_wr_idx[i] = r_tail[AW-1:0] + w_enq_n[AW-1:0];
            if (in_valid_i[i]) begin
                w_enq_n = w_enq_n + CW'(1);
            end
        end
    end

    assign w_enq_fire = (|in_valid_i) && in_ready_o && !flush_i;

    // ------------------------------------------------------------------------
    // Dequeue
    // Output lane k shows entry head+k whenever more than k entries are live,
    // which makes out_valid_o a contiguous run from lane 0 by construction.
    // ------------------------------------------------------------------------
    logic [CW-1:0] w_deq_n;
    logic [AW-1:0] w_rd_idx [DECODE_WIDTH];
    logic          w_deq_fire;

    always_comb begin
        w_deq_n     = '0;
        out_valid_o = '0;
        out_pc_o    = '0;
        out_inst_o  = '0;
        out_taken_o = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            w_rd_idx[k] = r_head[AW-1:0] + AW'(k);
            if (w_count > CW'(k)) begin
                out_valid_o[k]        = 1'b1;
                out_pc_o[k*32 +: 32]   = r_pc[w_rd_idx[k]];
                out_inst_o[k*32 +: 32] = r_inst[w_rd_idx[k]];
                out_taken_o[k]        = r_taken[w_rd_idx[k]];
                w_deq_n               = w_deq_n + CW'(1);
            end
        end
    end

    assign w_deq_fire = out_ready_i && !flush_i;

    // ------------------------------------------------------------------------
    // Pointer update. Flush wins over both enqueue and dequeue. Because the
    // enqueue count is bounded by the free space checked through in_ready_o,
    // tail - head can never exceed DEPTH.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= r_tail + w_enq_n;
            end
            if (w_deq_fire) begin
                r_head <= r_head + w_deq_n;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry write. Compacted indices are distinct, so several lanes can write
    // in the same cycle without conflict. New data becomes visible at the
    // outputs only after the tail pointer moves, i.e. the next cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_valid_i[i]) begin
                    r_pc[w_wr_idx[i]]    <= in_pc_i[i*32 +: 32];
                    r_inst[w_wr_idx[i]]  <= in_inst_i[i*32 +: 32];
                    r_taken[w_wr_idx[i]] <= in_taken_i[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_flush_cnt;

    // Stall cycles: fetch has something to give but there is no room for a
    // full group. Counters saturate rather than wrap and ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full_cycles <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if ((|in_valid_i) && !in_ready_o && (r_full_cycles != 32'hFFFF_FFFF)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_full_cycles_o = r_full_cycles;
    assign perf_flush_cnt_o   = r_flush_cnt;
`else
    // Counters are compiled out; the queue datapath above is unaffected.
`endif

endmodule
